// File: rtl/packet_assembler.sv
// Collects big-endian bytes into PKT_WIDTH-bit packets behind a one-deep output
// register, with an optional idle timeout that drops stalled partial packets.
module packet_assembler #(
  parameter int PKT_WIDTH      = 24,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  input  logic [7:0]           byte_in,
  output logic                 pkt_valid,
  input  logic                 pkt_ready,
  output logic [PKT_WIDTH-1:0] pkt,
  output logic                 timeout
);

  localparam int NUM_BYTES = ((PKT_WIDTH + 7) / 8) < 1 ? 1 : ((PKT_WIDTH + 7) / 8);
  localparam int TW        = NUM_BYTES * 8;
  localparam int IW        = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int CW_RAW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW        = (CW_RAW < 1) ? 1 : CW_RAW;

  logic [IW-1:0]        r_idx;
  logic [CW-1:0]        r_idle;
  logic [TW-1:0]        r_partial;
  logic [PKT_WIDTH-1:0] r_pkt;
  logic                 r_pktValid;
  logic                 r_timeout;

  logic          w_last;
  logic          w_accept;
  logic          w_load;
  logic          w_handoff;
  logic          w_idleCycle;
  logic          w_expire;
  logic [TW-1:0] w_full;

  assign w_last      = (r_idx == IW'(NUM_BYTES - 1));
  assign byte_ready  = arstn && (!w_last || !r_pktValid || pkt_ready);
  assign w_accept    = byte_valid && byte_ready;
  assign w_load      = w_accept && w_last;
  assign w_handoff   = r_pktValid && pkt_ready;
  assign w_idleCycle = (r_idx != '0) && !byte_valid;
  // Fires on the edge that would bring the idle count up to TIMEOUT_CYCLES.
  assign w_expire    = (TIMEOUT_CYCLES > 0) && w_idleCycle &&
                       (r_idle == CW'(TIMEOUT_CYCLES - 1));
  assign w_full      = (r_partial << 8) | TW'(byte_in);

  always_ff @(posedge clk) begin
    if (!arstn) begin
      r_idx      <= '0;
      r_idle     <= '0;
      r_partial  <= '0;
      r_pkt      <= '0;
      r_pktValid <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_expire;

      if (w_expire) begin
        r_idx     <= '0;
        r_idle    <= '0;
        r_partial <= '0;
      end else if (w_accept) begin
        r_idle <= '0;
        if (w_last) begin
          r_idx     <= '0;
          r_partial <= '0;
        end else begin
          r_idx     <= r_idx + 1'b1;
          r_partial <= w_full;
        end
      end else if (r_idx == '0) begin
        r_idle <= '0;
      end else if (w_idleCycle && (r_idle != '1)) begin
        r_idle <= r_idle + 1'b1;
      end

      // A load in the same cycle as a handoff replaces the packet without a gap.
      if (w_load) begin
        r_pkt      <= PKT_WIDTH'(w_full);
        r_pktValid <= 1'b1;
      end else if (w_handoff) begin
        r_pktValid <= 1'b0;
      end
    end
  end

  assign pkt_valid = r_pktValid;
  assign pkt       = r_pkt;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_packet_assembler.sv
// Directed bench for packet_assembler: a 20-bit instance with no timeout and a
// 24-bit instance with a 4-cycle idle timeout, each scenario hand-checked.
`timescale 1ns/1ps
module tb_packet_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arstn;

  logic        aValid, aReady, aPktValid, aPktReady, aTimeout;
  logic [7:0]  aByte;
  logic [19:0] aPkt;

  logic        bValid, bReady, bPktValid, bPktReady, bTimeout;
  logic [7:0]  bByte;
  logic [23:0] bPkt;

  int vectors     = 0;
  int miscompares = 0;

  packet_assembler #(.PKT_WIDTH(20)) dutA (
    .clk       (clk),
    .arstn     (arstn),
    .byte_valid(aValid),
    .byte_ready(aReady),
    .byte_in   (aByte),
    .pkt_valid (aPktValid),
    .pkt_ready (aPktReady),
    .pkt       (aPkt),
    .timeout   (aTimeout)
  );

  packet_assembler #(.PKT_WIDTH(24), .TIMEOUT_CYCLES(4)) dutB (
    .clk       (clk),
    .arstn     (arstn),
    .byte_valid(bValid),
    .byte_ready(bReady),
    .byte_in   (bByte),
    .pkt_valid (bPktValid),
    .pkt_ready (bPktReady),
    .pkt       (bPkt),
    .timeout   (bTimeout)
  );

  // Advance to just after the next rising edge so registered outputs are settled.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    arstn = 1'b0;
    aValid = 1'b1; aByte = 8'hFF; aPktReady = 1'b0;
    bValid = 1'b1; bByte = 8'hFF; bPktReady = 1'b0;
    #1;
    vectors++;
    if (aReady !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_a_byte_ready: got %b expected 0", aReady); end
    vectors++;
    if (bReady !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_b_byte_ready: got %b expected 0", bReady); end
    step;
    step;
    vectors++;
    if (aPktValid !== 1'b0 || aPkt !== 20'h0 || aTimeout !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_a_outputs: got valid=%b pkt=%h timeout=%b expected 0/00000/0", aPktValid, aPkt, aTimeout);
    end
    vectors++;
    if (bPktValid !== 1'b0 || bPkt !== 24'h0 || bTimeout !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_b_outputs: got valid=%b pkt=%h timeout=%b expected 0/000000/0", bPktValid, bPkt, bTimeout);
    end
    aValid = 1'b0;
    bValid = 1'b0;
    arstn  = 1'b1;
    step;
    vectors++;
    if (bPktValid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_release_valid: got %b expected 0", bPktValid); end
  endtask

  // 20-bit packet from three bytes: the top nibble of the first byte is padding.
  task automatic test_width20;
    logic [7:0] seq [3];
    seq = '{8'hF5, 8'h12, 8'h34};
    aPktReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      aValid = 1'b1;
      aByte  = seq[k];
      #1;
      vectors++;
      if (aReady !== 1'b1) begin miscompares++; $display("[TB] FAIL w20_ready_%0d: got %b expected 1", k, aReady); end
      vectors++;
      if (aPktValid !== 1'b0) begin miscompares++; $display("[TB] FAIL w20_early_valid_%0d: got %b expected 0", k, aPktValid); end
      step;
    end
    aValid = 1'b0;
    vectors++;
    if (aPktValid !== 1'b1 || aPkt !== 20'h51234) begin
      miscompares++; $display("[TB] FAIL w20_packet: got valid=%b pkt=%h expected 1/51234", aPktValid, aPkt);
    end
    step;
    vectors++;
    if (aPktValid !== 1'b0) begin miscompares++; $display("[TB] FAIL w20_one_cycle: got %b expected 0", aPktValid); end
  endtask

  // Nine bytes with no gaps must yield three packets on consecutive boundaries.
  task automatic test_stream;
    logic [23:0] exp;
    bPktReady = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bValid = 1'b1;
      bByte  = 8'(i + 1);
      #1;
      vectors++;
      if (bReady !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_ready_%0d: got %b expected 1", i, bReady); end
      step;
      if (i % 3 == 2) begin
        exp = {8'(i - 1), 8'(i), 8'(i + 1)};
        vectors++;
        if (bPktValid !== 1'b1 || bPkt !== exp) begin
          miscompares++; $display("[TB] FAIL stream_pkt_%0d: got valid=%b pkt=%h expected 1/%h", i, bPktValid, bPkt, exp);
        end
      end else begin
        vectors++;
        if (bPktValid !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_gap_%0d: got %b expected 0", i, bPktValid); end
      end
    end
    bValid = 1'b0;
    step;
    vectors++;
    if (bPktValid !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_drain: got %b expected 0", bPktValid); end
  endtask

  // Packet A is held; B's first two bytes enter, its last byte waits for the slot.
  task automatic test_back_to_back;
    logic [7:0] seqA [3];
    logic [7:0] seqB [3];
    seqA = '{8'hAA, 8'hBB, 8'hCC};
    seqB = '{8'h11, 8'h22, 8'h33};
    bPktReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bValid = 1'b1;
      bByte  = seqA[k];
      #1;
      vectors++;
      if (bReady !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_a_ready_%0d: got %b expected 1", k, bReady); end
      step;
    end
    vectors++;
    if (bPktValid !== 1'b1 || bPkt !== 24'hAABBCC) begin
      miscompares++; $display("[TB] FAIL bp_a_loaded: got valid=%b pkt=%h expected 1/aabbcc", bPktValid, bPkt);
    end
    for (int k = 0; k < 2; k++) begin
      bByte = seqB[k];
      #1;
      vectors++;
      if (bReady !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_b_ready_%0d: got %b expected 1", k, bReady); end
      step;
    end
    bByte = seqB[2];
    #1;
    vectors++;
    if (bReady !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_stall_ready: got %b expected 0", bReady); end
    step;
    step;
    vectors++;
    if (bPktValid !== 1'b1 || bPkt !== 24'hAABBCC || bReady !== 1'b0 || bTimeout !== 1'b0) begin
      miscompares++; $display("[TB] FAIL bp_hold: got valid=%b pkt=%h ready=%b timeout=%b expected 1/aabbcc/0/0", bPktValid, bPkt, bReady, bTimeout);
    end
    bPktReady = 1'b1;
    #1;
    vectors++;
    if (bReady !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_release_ready: got %b expected 1", bReady); end
    step;
    bValid = 1'b0;
    vectors++;
    if (bPktValid !== 1'b1 || bPkt !== 24'h112233) begin
      miscompares++; $display("[TB] FAIL bp_b_loaded: got valid=%b pkt=%h expected 1/112233", bPktValid, bPkt);
    end
    step;
    vectors++;
    if (bPktValid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_drain: got %b expected 0", bPktValid); end
  endtask

  // Four idle cycles after one byte drop it; a following packet starts clean.
  task automatic test_timeout;
    logic expPulse;
    logic [7:0] seq [3];
    seq = '{8'h00, 8'hAB, 8'hCD};
    bPktReady = 1'b1;
    bValid = 1'b1;
    bByte  = 8'h77;
    #1;
    step;
    bValid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step;
      expPulse = (c == 4);
      vectors++;
      if (bTimeout !== expPulse) begin miscompares++; $display("[TB] FAIL to_pulse_c%0d: got %b expected %b", c, bTimeout, expPulse); end
    end
    step;
    vectors++;
    if (bTimeout !== 1'b0 || bPktValid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL to_after: got timeout=%b valid=%b expected 0/0", bTimeout, bPktValid);
    end
    for (int k = 0; k < 3; k++) begin
      bValid = 1'b1;
      bByte  = seq[k];
      #1;
      step;
    end
    bValid = 1'b0;
    vectors++;
    if (bPktValid !== 1'b1 || bPkt !== 24'h00ABCD) begin
      miscompares++; $display("[TB] FAIL to_clean_pkt: got valid=%b pkt=%h expected 1/00abcd", bPktValid, bPkt);
    end
    step;
  endtask

  // A three-cycle gap stays under the limit, so the byte after it lands at idx 2.
  task automatic test_no_timeout;
    bPktReady = 1'b1;
    bValid = 1'b1;
    bByte  = 8'h5A;
    #1;
    step;
    bValid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step;
      vectors++;
      if (bTimeout !== 1'b0) begin miscompares++; $display("[TB] FAIL nto_gap_c%0d: got %b expected 0", c, bTimeout); end
    end
    bValid = 1'b1;
    bByte  = 8'h6B;
    #1;
    step;
    vectors++;
    if (bTimeout !== 1'b0 || bPktValid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL nto_second: got timeout=%b valid=%b expected 0/0", bTimeout, bPktValid);
    end
    bByte = 8'h7C;
    #1;
    step;
    bValid = 1'b0;
    vectors++;
    if (bPktValid !== 1'b1 || bPkt !== 24'h5A6B7C) begin
      miscompares++; $display("[TB] FAIL nto_pkt: got valid=%b pkt=%h expected 1/5a6b7c", bPktValid, bPkt);
    end
    step;
  endtask

  // Reset with a held packet and two partial bytes must drop everything.
  task automatic test_reset_mid;
    logic [7:0] seqC [3];
    logic [7:0] seqN [3];
    seqC = '{8'hC1, 8'hC2, 8'hC3};
    seqN = '{8'h0A, 8'h0B, 8'h0C};
    bPktReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bValid = 1'b1;
      bByte  = seqC[k];
      #1;
      step;
    end
    bByte = 8'hE1;
    #1;
    step;
    bByte = 8'hE2;
    #1;
    step;
    vectors++;
    if (bPktValid !== 1'b1 || bPkt !== 24'hC1C2C3) begin
      miscompares++; $display("[TB] FAIL rm_held: got valid=%b pkt=%h expected 1/c1c2c3", bPktValid, bPkt);
    end
    bValid = 1'b0;
    arstn  = 1'b0;
    #1;
    vectors++;
    if (bReady !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_ready_in_reset: got %b expected 0", bReady); end
    step;
    vectors++;
    if (bPktValid !== 1'b0 || bPkt !== 24'h0) begin
      miscompares++; $display("[TB] FAIL rm_cleared: got valid=%b pkt=%h expected 0/000000", bPktValid, bPkt);
    end
    arstn = 1'b1;
    bPktReady = 1'b1;
    step;
    vectors++;
    if (bPktValid !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_no_ghost: got %b expected 0", bPktValid); end
    for (int k = 0; k < 3; k++) begin
      bValid = 1'b1;
      bByte  = seqN[k];
      #1;
      step;
    end
    bValid = 1'b0;
    vectors++;
    if (bPktValid !== 1'b1 || bPkt !== 24'h0A0B0C) begin
      miscompares++; $display("[TB] FAIL rm_clean_pkt: got valid=%b pkt=%h expected 1/0a0b0c", bPktValid, bPkt);
    end
    step;
  endtask

  // Runs every scenario in order, then prints the summary.
  initial begin
    test_reset;
    test_width20;
    test_stream;
    test_back_to_back;
    test_timeout;
    test_no_timeout;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guards against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run still active at 200000ns, expected completion well before");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
